// File: rtl/alu_dispatch.sv
// alu_dispatch: accepts ALU commands, issues them to an execution unit, returns one response per command.
// Define ALU_DISPATCH_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles without unit_done.
module alu_dispatch #(
   parameter int DATA_WIDTH     = 1024,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_opcode,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  unit_start,
   output logic [2:0]            unit_op,
   output logic [DATA_WIDTH-1:0] unit_operand,
   input  logic                  unit_done,
   input  logic [DATA_WIDTH-1:0] unit_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [2:0] op, op_nx;
   logic [DATA_WIDTH-1:0] operand, operand_nx, data, data_nx;
   logic err, err_nx;
   logic expired;
`ifdef ALU_DISPATCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt, cnt_nx;
   // counter is zero on entry to WAIT because it is held clear in every other state
   assign cnt_nx  = (state == WAIT) ? cnt + CW'(1) : '0;
   assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= cnt_nx;
`else
   assign expired = 1'b0;
`endif
   always_comb begin
      state_nx   = state;
      op_nx      = op;
      operand_nx = operand;
      data_nx    = data;
      err_nx     = err;
      case (state)
         IDLE: if (cmd_valid) begin
            op_nx      = cmd_opcode;
            operand_nx = cmd_data;
            state_nx   = cmd_opcode[2] ? RESP : ISSUE;
            if (cmd_opcode[2]) begin
               data_nx = '0;
               err_nx  = 1'b1;
            end
         end
         ISSUE: state_nx = WAIT;
         WAIT: if (unit_done || expired) begin
            data_nx  = unit_done ? unit_result : '0;
            err_nx   = !unit_done;
            state_nx = RESP;
         end
         RESP: state_nx = rsp_ready ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         op      <= '0;
         operand <= '0;
         data    <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nx;
         op      <= op_nx;
         operand <= operand_nx;
         data    <= data_nx;
         err     <= err_nx;
      end
   assign cmd_ready    = state == IDLE;
   assign busy         = state != IDLE;
   assign unit_start   = state == ISSUE;
   assign unit_op      = op;
   assign unit_operand = operand;
   assign rsp_valid    = state == RESP;
   assign rsp_data     = data;
   assign rsp_err      = err;
endmodule
